rob_mem_requester: RTL

- Initiator/requester end of the ROB memory interface; the memory model is the responder.
- Accepts address requests from upstream, allocates an ID (tag) per request and drives req_val/req_addr/req_ID to memory.
- Absorbs out-of-order rsp_val/rsp_ID/rsp_data returns into a tag-indexed reorder buffer and delivers read data downstream strictly in request order over a valid/ready handshake.
- Sits between request generator and memory.

---
 rtl/rob_mem_requester_pkg.sv | 18 +
 rtl/rob_mem_requester_if.sv | 32 +++
 rtl/rob_mem_requester_tag_ring.sv | 53 +++++
 rtl/rob_mem_requester.sv | 105 ++++++++++
 4 files changed

// File: rtl/rob_mem_requester_pkg.sv
// Shared widths and types for the ROB memory requester.
// Optional unexpected-response checking is enabled with ROB_ERR_CHECK_EN.
package rob_package;

  localparam int AWIDTH = 16;
  localparam int DWIDTH = 32;
  localparam int SWIDTH = 2;
  localparam int DEPTH  = 2 ** SWIDTH;

  typedef logic [SWIDTH-1:0] tag_t;

  typedef struct packed {
    logic              pend;
    logic              done;
    logic [DWIDTH-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_mem_requester_if.sv
// Request, memory and in-order delivery signals of the ROB requester.
// master is the requester's view; slave is the environment's view.
interface rob_mem_requester_if #(
  parameter int AWIDTH = rob_package::AWIDTH,
  parameter int DWIDTH = rob_package::DWIDTH,
  parameter int SWIDTH = rob_package::SWIDTH
) ();

  logic              in_val;
  logic [AWIDTH-1:0] in_addr;
  logic              in_rdy;
  logic              req_val;
  logic [AWIDTH-1:0] req_addr;
  logic [SWIDTH-1:0] req_ID;
  logic              rsp_val;
  logic [SWIDTH-1:0] rsp_ID;
  logic [DWIDTH-1:0] rsp_data;
  logic              out_val;
  logic [DWIDTH-1:0] out_data;
  logic              out_rdy;

  modport master (
    input  in_val, in_addr, rsp_val, rsp_ID, rsp_data, out_rdy,
    output in_rdy, req_val, req_addr, req_ID, out_val, out_data
  );

  modport slave (
    output in_val, in_addr, rsp_val, rsp_ID, rsp_data, out_rdy,
    input  in_rdy, req_val, req_addr, req_ID, out_val, out_data
  );

endinterface

// File: rtl/rob_mem_requester_tag_ring.sv
// Head/tail/count bookkeeping for the reorder buffer tags.
// Tags wrap modulo 2**SWIDTH; count spans 0..2**SWIDTH inclusive.
module rob_tag_ring #(
  parameter int SWIDTH = rob_package::SWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept_i,
  input  logic              retire_i,
  output logic              in_rdy_o,
  output logic [SWIDTH:0]   occupancy_o,
  output logic [SWIDTH-1:0] alloc_tag_o,
  output logic [SWIDTH-1:0] retire_tag_o
);

  localparam logic [SWIDTH:0] FULL = {1'b1, {SWIDTH{1'b0}}};

  logic [SWIDTH-1:0] head_q, head_d;
  logic [SWIDTH-1:0] tail_q, tail_d;
  logic [SWIDTH:0]   count_q, count_d;

  // Simultaneous accept and retire leave the count unchanged.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (accept_i) tail_d = tail_q + 1'b1;
    if (retire_i) head_d = head_q + 1'b1;
    if (accept_i && !retire_i) begin
      count_d = count_q + 1'b1;
    end else if (retire_i && !accept_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign in_rdy_o     = (count_q != FULL);
  assign occupancy_o  = count_q;
  assign alloc_tag_o  = tail_q;
  assign retire_tag_o = head_q;

endmodule

// File: rtl/rob_mem_requester.sv
// Tags memory requests, reorders out-of-order responses, delivers data in order.
// Define ROB_ERR_CHECK_EN to flag and drop responses to idle or completed tags.
module rob_mem_requester #(
  parameter int AWIDTH = rob_package::AWIDTH,
  parameter int DWIDTH = rob_package::DWIDTH,
  parameter int SWIDTH = rob_package::SWIDTH
) (
  input  logic                clk,
  input  logic                rst,
  rob_mem_requester_if.master bus,
  output logic [SWIDTH:0]     occupancy,
  output logic                err_unexp
);

  localparam int DEPTH = 2 ** SWIDTH;

  logic              in_rdy;
  logic              accept;
  logic              retire;
  logic              rsp_wr;
  logic [SWIDTH-1:0] alloc_tag;
  logic [SWIDTH-1:0] head_tag;

  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  done_q;
  logic [DWIDTH-1:0] data_q [DEPTH];

  logic              req_val_q;
  logic [AWIDTH-1:0] req_addr_q;
  logic [SWIDTH-1:0] req_id_q;

  rob_tag_ring #(.SWIDTH(SWIDTH)) u_ring (
    .clk          (clk),
    .rst          (rst),
    .accept_i     (accept),
    .retire_i     (retire),
    .in_rdy_o     (in_rdy),
    .occupancy_o  (occupancy),
    .alloc_tag_o  (alloc_tag),
    .retire_tag_o (head_tag)
  );

  assign accept       = bus.in_val & in_rdy;
  assign bus.out_val  = pend_q[head_tag] & done_q[head_tag];
  assign bus.out_data = data_q[head_tag];
  assign retire       = bus.out_val & bus.out_rdy;
  assign bus.in_rdy   = in_rdy;

`ifdef ROB_ERR_CHECK_EN
  logic err_q;

  assign rsp_wr = bus.rsp_val & pend_q[bus.rsp_ID] & ~done_q[bus.rsp_ID];

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (bus.rsp_val && !rsp_wr) begin
      err_q <= 1'b1;
    end
  end

  assign err_unexp = err_q;
`else
  assign rsp_wr    = bus.rsp_val;
  assign err_unexp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      req_val_q  <= 1'b0;
      req_addr_q <= '0;
      req_id_q   <= '0;
    end else begin
      req_val_q <= accept;
      if (accept) begin
        req_addr_q <= bus.in_addr;
        req_id_q   <= alloc_tag;
      end
    end
  end

  assign bus.req_val  = req_val_q;
  assign bus.req_addr = req_addr_q;
  assign bus.req_ID   = req_id_q;

  // Full blocks an accept into the head slot, so these updates never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      done_q <= '0;
    end else begin
      if (retire) begin
        pend_q[head_tag] <= 1'b0;
        done_q[head_tag] <= 1'b0;
      end
      if (accept) pend_q[alloc_tag] <= 1'b1;
      if (rsp_wr) done_q[bus.rsp_ID] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_wr) data_q[bus.rsp_ID] <= bus.rsp_data;
  end

endmodule
